// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: exception/interrupt sequencer for the CP0 register block.
// Samples MEM-stage exception flags and synchronised interrupt lines,
// takes the highest-priority event, and issues one registered CP0 update
// plus a pipeline flush/redirect held for FLUSH_CYCLES cycles.
// Optional feature macro: CP0_TIMER_INT_EN. When it is defined, timer_int
// is ORed into IP7 ahead of the synchroniser.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_stall,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_addr,
  input  logic        mem_in_delayslot,
  input  logic        exc_adel_if,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_sys,
  input  logic        exc_bp,
  input  logic        exc_adel_ld,
  input  logic        exc_ades,
  input  logic        exc_eret,
  input  logic [5:0]  hw_int,
  input  logic        timer_int,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  cp0_ip_o,
  output logic        exc_we,
  output logic [31:0] exc_epc,
  output logic [4:0]  exc_code,
  output logic        exc_bd,
  output logic        eret_we,
  output logic        badvaddr_we,
  output logic [31:0] badvaddr,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [5:0]  ip_raw, ip_s1, ip_s2;
  logic        int_pend, any_exc, accept;

  logic        exc_we_n, eret_we_n, badvaddr_we_n, flush_n, redirect_n, exc_bd_n;
  logic [4:0]  exc_code_n;
  logic [31:0] exc_epc_n, badvaddr_n, redirect_pc_n;

  // Bits of the forwarded registers that the sequencer does not look at.
`ifdef CP0_TIMER_INT_EN
  logic unused_bits;
  assign unused_bits = ^{cp0_status[31:16], cp0_status[9:2], cp0_cause};
`else
  logic unused_bits;
  assign unused_bits = ^{cp0_status[31:16], cp0_status[9:2], cp0_cause, timer_int};
`endif

  // Raw interrupt vector presented to the synchroniser (IP7 is bit 5).
  always_comb begin
`ifdef CP0_TIMER_INT_EN
    ip_raw = {hw_int[5] | timer_int, hw_int[4:0]};
`else
    ip_raw = hw_int;
`endif
  end

  // Two-flop synchroniser for the asynchronous interrupt lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_s1 <= '0;
      ip_s2 <= '0;
    end else begin
      // NOTE: non-blocking assignments let both flops sample pre-edge values,
      // which is what gives the two-stage delay; blocking would collapse it.
      ip_s1 <= ip_raw;
      ip_s2 <= ip_s1;
    end
  end

  assign cp0_ip_o = ip_s2;
  assign int_pend = cp0_status[0] & ~cp0_status[1] & |(ip_s2 & cp0_status[15:10]);
  assign any_exc  = exc_adel_if | exc_ri | exc_ov | exc_sys | exc_bp |
                    exc_adel_ld | exc_ades | exc_eret;
  assign accept   = (state == IDLE) & mem_valid & ~mem_stall & (int_pend | any_exc);

  // Next-state, drain counter and next registered outputs.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; a missing default here would infer a latch.
    state_n       = state;
    cnt_n         = cnt;
    flush_n       = 1'b0;
    redirect_n    = 1'b0;
    exc_we_n      = 1'b0;
    eret_we_n     = 1'b0;
    badvaddr_we_n = 1'b0;
    exc_code_n    = exc_code;
    exc_epc_n     = exc_epc;
    exc_bd_n      = exc_bd;
    badvaddr_n    = badvaddr;
    redirect_pc_n = redirect_pc;

    case (state)
      IDLE: begin
        if (accept) begin
          state_n       = FLUSH;
          cnt_n         = CNT_INIT;
          flush_n       = 1'b1;
          redirect_n    = 1'b1;
          redirect_pc_n = EXC_VECTOR;
          exc_we_n      = 1'b1;
          exc_bd_n      = mem_in_delayslot;
          exc_epc_n     = mem_in_delayslot ? mem_pc - 32'd4 : mem_pc;
          if (int_pend)         exc_code_n = 5'h00;
          else if (exc_adel_if) begin
            exc_code_n    = 5'h04;
            badvaddr_we_n = 1'b1;
            badvaddr_n    = mem_pc;
          end
          else if (exc_ri)      exc_code_n = 5'h0A;
          else if (exc_ov)      exc_code_n = 5'h0C;
          else if (exc_sys)     exc_code_n = 5'h08;
          else if (exc_bp)      exc_code_n = 5'h09;
          else if (exc_adel_ld) begin
            exc_code_n    = 5'h04;
            badvaddr_we_n = 1'b1;
            badvaddr_n    = mem_addr;
          end
          else if (exc_ades) begin
            exc_code_n    = 5'h05;
            badvaddr_we_n = 1'b1;
            badvaddr_n    = mem_addr;
          end
          else begin
            // ERET: return to EPC; the EPC/Cause fields are left untouched.
            exc_we_n      = 1'b0;
            eret_we_n     = 1'b1;
            exc_bd_n      = exc_bd;
            exc_epc_n     = exc_epc;
            redirect_pc_n = cp0_epc;
          end
        end
      end
      FLUSH: begin
        flush_n = 1'b1;
        if (cnt == 4'd0) begin
          state_n = IDLE;
          flush_n = 1'b0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counter and registered CP0/pipeline outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      flush_o     <= 1'b0;
      redirect_o  <= 1'b0;
      exc_we      <= 1'b0;
      eret_we     <= 1'b0;
      badvaddr_we <= 1'b0;
      exc_code    <= '0;
      exc_epc     <= '0;
      exc_bd      <= 1'b0;
      badvaddr    <= '0;
      redirect_pc <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      flush_o     <= flush_n;
      redirect_o  <= redirect_n;
      exc_we      <= exc_we_n;
      eret_we     <= eret_we_n;
      badvaddr_we <= badvaddr_we_n;
      exc_code    <= exc_code_n;
      exc_epc     <= exc_epc_n;
      exc_bd      <= exc_bd_n;
      badvaddr    <= badvaddr_n;
      redirect_pc <= redirect_pc_n;
    end
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Exception/interrupt sequencer for the CP0 register block.
- Samples MEM-stage exception flags and synchronised hardware interrupt lines, prioritises them, and issues one registered CP0 update (EPC/Cause/Status.EXL/BadVAddr).
- Drives the pipeline flush and PC redirect for a fixed drain window.
- Reads Status/Cause/EPC as already-forwarded values so back-to-back MTC0 writes are honoured.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for all exceptions except ERET.
- FLUSH_CYCLES, 2, cycles flush_o is held after acceptance; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mem_valid  in  1  MEM slot holds a real instruction, not a bubble.
- mem_stall  in  1  MEM stage stalled; no acceptance this cycle.
- mem_pc  in  32  PC of the MEM instruction.
- mem_addr  in  32  data address of the MEM load/store.
- mem_in_delayslot  in  1  MEM instruction sits in a branch delay slot.
- exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades, exc_eret  in  1 each  exception flags.
- hw_int  in  6  asynchronous hardware interrupt lines.
- timer_int  in  1  timer interrupt (see Optional Feature).
- cp0_status  in  32  forwarded Status.
- cp0_cause  in  32  forwarded Cause.
- cp0_epc  in  32  forwarded EPC.
- cp0_ip_o  out  6  synchronised Cause.IP[7:2].
- exc_we  out  1  one-cycle pulse: write EPC, Cause.ExcCode, Cause.BD, and set Status.EXL.
- exc_epc  out  32  EPC value.
- exc_code  out  5  ExcCode value.
- exc_bd  out  1  BD value.
- eret_we  out  1  one-cycle pulse: clear Status.EXL.
- badvaddr_we  out  1  one-cycle pulse: write BadVAddr.
- badvaddr  out  32  BadVAddr value.
- flush_o  out  1  flush IF..MEM.
- redirect_o  out  1  one-cycle pulse: load redirect_pc.
- redirect_pc  out  32  new fetch PC.

Behaviour:
- Reset: all outputs 0; state IDLE; synchroniser flops 0; flush counter 0.
- Interrupt path:
  - hw_int goes through a 2-flop synchroniser; cp0_ip_o = synchronised bits, so latency is 2 cycles.
  - int_pend = Status.IE(bit0) & ~Status.EXL(bit1) & |(cp0_ip_o & Status.IM[15:10]).
- Accept condition: state IDLE & mem_valid & ~mem_stall & (int_pend | any exception flag).
- Priority, highest first, with ExcCode:
  - Int 0x00
  - AdEL-fetch 0x04
  - RI 0x0A
  - Ov 0x0C
  - Sys 0x08
  - Bp 0x09
  - AdEL-load 0x04
  - AdES 0x05
  - ERET (no code)
- Outputs on acceptance are registered and appear the cycle after acceptance (cycle T+1):
  - Non-ERET:
    - exc_we=1; exc_code per the priority list.
    - exc_bd=mem_in_delayslot.
    - exc_epc = mem_in_delayslot ? mem_pc-4 : mem_pc (32-bit wrap-around).
    - redirect_pc=EXC_VECTOR.
  - ERET: eret_we=1; redirect_pc=cp0_epc sampled at acceptance; exc_we=0.
  - badvaddr_we=1 only for AdEL/AdES: badvaddr=mem_pc for fetch, mem_addr for load/store.
  - redirect_o=1 and flush_o=1.
  - State moves to FLUSH with counter=FLUSH_CYCLES-1.
- FLUSH state:
  - flush_o=1 every cycle; write strobes and redirect_o are 0 after T+1.
  - Counter decrements each cycle; at 0, the next cycle is IDLE with flush_o=0.
  - All flags and interrupts are ignored while in FLUSH; no queuing.
- Simultaneous events:
  - Only the highest-priority event is taken; the rest are dropped (the pipeline flushes them).
  - Interrupt plus ERET on the same instruction: interrupt wins and EPC=mem_pc.
- mem_stall=1: nothing accepted. Flags are re-evaluated on each unstalled cycle.
- rst_n low at any time, including mid-FLUSH: immediately IDLE with all outputs 0.

Optional Feature:
- CP0_TIMER_INT_EN defined:
  - timer_int is ORed into synchroniser bit 5 (IP7) before synchronisation.
  - Cause.TI (bit 30) is reflected by the interrupt test, i.e. IP7 is pending when timer_int is high.
- CP0_TIMER_INT_EN undefined:
  - timer_int is ignored; IP7 = hw_int[5] only.
  - The port remains present.

Test Plan:
- Sys at mem_pc=0x8000_0010, not delay slot -> next cycle: exc_we=1, exc_code=0x08, exc_epc=0x8000_0010, redirect_pc=0xBFC00380; flush_o high for 2 cycles.
- AdES in delay slot, mem_pc=0x8000_0104, mem_addr=0x1001 -> exc_code=0x05, exc_bd=1, exc_epc=0x8000_0100, badvaddr_we=1, badvaddr=0x1001.
- Status=0x0000_0401, hw_int[0] raised -> cp0_ip_o[0]=1 after 2 cycles; at next mem_valid, exc_code=0x00. Repeat with Status.EXL=1 -> no acceptance.
- ERET with cp0_epc=0x8000_2000 -> eret_we=1, exc_we=0, redirect_pc=0x8000_2000. ERET plus pending interrupt together -> interrupt taken.
- RI and Ov together, then Sys asserted during FLUSH -> only exc_code=0x0A is issued; Sys is ignored; flush_o drops after FLUSH_CYCLES.
- rst_n pulled low in the first FLUSH cycle -> flush_o=0 and all strobes=0 immediately; Sys after release -> accepted normally. With CP0_TIMER_INT_EN, timer_int=1 and IM7=1 -> exc_code=0x00.
